// File: rtl/encoder_menu_pkg.sv
// Shared state encoding and elaboration helpers for the encoder menu controller.
package encoder_menu_pkg;

    localparam logic ST_SELECT = 1'b0;
    localparam logic ST_EDIT   = 1'b1;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_stepper.sv
// Combinational saturating step of a W-bit value: clamps at MAX_VAL going up, at 0 going down.
module sat_stepper #(
    parameter int W       = 8,
    parameter int MAX_VAL = 255
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] result
);

    localparam logic [W:0] MAX_EXT = (W+1)'(MAX_VAL);

    logic [W:0] sum;

    // One extra bit on the sum so an overflow past 2^W-1 still saturates.
    always_comb begin
        sum    = {1'b0, value} + {1'b0, step};
        result = value;
        if (up && !dn) begin
            result = (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
        end else if (dn && !up) begin
            result = (value < step) ? '0 : value - step;
        end
    end

endmodule

// File: rtl/encoder_menu_ctrl.sv
// Rotary-encoder menu: select a parameter, edit a shadow copy, commit on button or abandon on idle.
// Optional macro ENCODER_MENU_ACCEL_EN enables larger steps during fast rotation in EDIT.
module encoder_menu_ctrl
    import encoder_menu_pkg::*;
#(
    parameter int NUM_PARAMS = 4,
    parameter int W          = 8,
    parameter int MAX_VAL    = 255,
    parameter int RESET_VAL  = 0,
`ifdef ENCODER_MENU_ACCEL_EN
    parameter int ACCEL_WIN  = 5_000_000,
    parameter int ACCEL_STEP = 8,
`endif
    parameter int TIMEOUT    = 10_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inc,
    input  logic                            dec,
    input  logic                            btn,
    output logic [clog2(NUM_PARAMS)-1:0]    sel,
    output logic                            editing,
    output logic [NUM_PARAMS*W-1:0]         params,
    output logic [W-1:0]                    disp,
    output logic                            upd,
    output logic                            timeout
);

    localparam int SEL_W  = clog2(NUM_PARAMS);
    localparam int IDLE_W = clog2(TIMEOUT);
    localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(NUM_PARAMS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [W-1:0]      RST_WORD  = W'(RESET_VAL);

    logic                    state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_PARAMS*W-1:0] params_q, params_d;
    logic [W-1:0]            shadow_q, shadow_d;
    logic                    upd_q, upd_d;
    logic                    timeout_q, timeout_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;

    logic         step_up, step_dn;
    logic [W-1:0] step_size;
    logic [W-1:0] stepped;

    assign step_up = inc & ~dec;
    assign step_dn = dec & ~inc;

    sat_stepper #(
        .W       (W),
        .MAX_VAL (MAX_VAL)
    ) u_stepper (
        .value  (shadow_q),
        .step   (step_size),
        .up     (step_up),
        .dn     (step_dn),
        .result (stepped)
    );

`ifdef ENCODER_MENU_ACCEL_EN
    localparam int GAP_W = clog2(ACCEL_WIN + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ACCEL_WIN);

    logic [GAP_W-1:0] gap_q, gap_d;

    // Held at the window limit outside EDIT so the first edit step is always a single count.
    always_comb begin
        gap_d = gap_q;
        if (state_q == ST_SELECT || btn) begin
            gap_d = GAP_MAX;
        end else if (step_up || step_dn) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) gap_q <= GAP_MAX;
        else     gap_q <= gap_d;
    end

    assign step_size = (state_q == ST_EDIT && gap_q < GAP_MAX) ? W'(ACCEL_STEP) : W'(1);
`else
    assign step_size = W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SELECT;
            sel_q     <= '0;
            params_q  <= {NUM_PARAMS{RST_WORD}};
            shadow_q  <= '0;
            upd_q     <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            params_q  <= params_d;
            shadow_q  <= shadow_d;
            upd_q     <= upd_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
        end
    end

    // The button outranks any same-cycle step in both states.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        params_d  = params_q;
        shadow_d  = shadow_q;
        upd_d     = 1'b0;
        timeout_d = 1'b0;
        idle_d    = idle_q;
        case (state_q)
            ST_SELECT: begin
                if (btn) begin
                    shadow_d = params_q[sel_q*W +: W];
                    state_d  = ST_EDIT;
                    idle_d   = '0;
                end else if (step_up) begin
                    sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                end else if (step_dn) begin
                    sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
                end
            end
            default: begin
                if (btn) begin
                    params_d[sel_q*W +: W] = shadow_q;
                    upd_d   = 1'b1;
                    state_d = ST_SELECT;
                    idle_d  = '0;
                end else if (step_up || step_dn) begin
                    shadow_d = stepped;
                    idle_d   = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d   = ST_SELECT;
                    shadow_d  = '0;
                    timeout_d = 1'b1;
                    idle_d    = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        editing = (state_q == ST_EDIT);
        disp    = (state_q == ST_EDIT) ? shadow_q : params_q[sel_q*W +: W];
    end

    assign sel     = sel_q;
    assign params  = params_q;
    assign upd     = upd_q;
    assign timeout = timeout_q;

endmodule
